ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard using the PS/2 request-to-send protocol. It drives the shared open-drain PS/2 clock and data lines alongside the existing keyboard receive path, and reports the device acknowledge. While `busy` is high, the receive path ignores line activity.

---
 rtl/ps2_host_tx.sv | 140 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame on device clock,
// then device ACK sampling with a per-edge timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned CW = (TW > IW) ? TW : IW;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            data_meta_q, data_sync_q;
    logic [9:0]      frame_q, frame_d;
    logic [3:0]      edge_q, edge_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            fall;
    logic            in_link;
    logic            expire;

    assign fall    = clk_prev_q & ~clk_sync_q;
    assign in_link = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // A device clock edge in the expiry cycle takes priority over the timeout.
    assign expire  = in_link && (cnt_q == '0) && !fall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            frame_q     <= '1;
            edge_q      <= '0;
            cnt_q       <= '0;
            data_oe_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            frame_q     <= frame_d;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            data_oe_q   <= data_oe_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (tx_start) state_d = S_INHIBIT;
            S_INHIBIT:   if (cnt_q == '0) state_d = S_RTS;
            S_RTS:       state_d = S_SHIFT;
            S_SHIFT:     if (expire) state_d = S_FIN;
                         else if (fall && edge_q == 4'd9) state_d = S_ACK;
            S_ACK:       if (expire) state_d = S_FIN;
                         else if (fall) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (expire) state_d = S_FIN;
                         else if (clk_sync_q && data_sync_q) state_d = S_FIN;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_d   = frame_q;
        edge_d    = edge_q;
        cnt_d     = cnt_q;
        data_oe_d = data_oe_q;
        ack_d     = ack_q;
        err_d     = err_q;
        if (state_q == S_IDLE && tx_start) begin
            frame_d   = {1'b1, ~^tx_data, tx_data};
            edge_d    = '0;
            cnt_d     = CW'(INHIBIT_CYCLES - 1);
            data_oe_d = 1'b0;
            ack_d     = 1'b0;
            err_d     = 1'b0;
        end else if (state_q == S_INHIBIT) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end else if (state_q == S_RTS) begin
            data_oe_d = 1'b1;
            cnt_d     = CW'(TIMEOUT_CYCLES);
        end else if (in_link) begin
            if (fall) cnt_d = CW'(TIMEOUT_CYCLES);
            else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            if (expire) begin
                data_oe_d = 1'b0;
                ack_d     = 1'b0;
                err_d     = 1'b1;
            end else if (fall && state_q == S_SHIFT) begin
                data_oe_d = ~frame_q[0];
                frame_d   = {1'b1, frame_q[9:1]};
                edge_d    = edge_q + 4'd1;
            end else if (fall && state_q == S_ACK) begin
                ack_d = ~data_sync_q;
                err_d = data_sync_q;
            end
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_FIN);
        done        = (state_q == S_FIN);
        ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
        ps2_data_oe = (state_q == S_RTS) || data_oe_q;
        ack_ok      = ack_q;
        error       = err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device,
// frame model from byte arithmetic, and a per-cycle output checker.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 8;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy, done, ack_ok, error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done), .ack_ok(ack_ok), .error(error),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame as the device must see it: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    bit          active = 1'b0;
    int unsigned acc_cyc = 0;
    bit          exp_ack = 1'b0, exp_err = 1'b0;
    int          done_cnt = 0;
    int unsigned done_cyc = 0;

    always @(negedge clk) begin
        int unsigned t;
        if (clrn) begin
            if (active) begin
                t = cyc - acc_cyc;
                if (t == 0) begin
                    chk("busy_before_accept", busy, 1'b0);
                end else if (t <= INH + 1) begin
                    chk("inhibit_clk_oe", ps2_clk_oe, 1'b1);
                    chk("inhibit_data_oe", ps2_data_oe, (t == INH + 1) ? 1'b1 : 1'b0);
                end else if (t == INH + 2) begin
                    chk("shift_clk_release", ps2_clk_oe, 1'b0);
                    chk("start_bit_held", ps2_data_oe, 1'b1);
                end
                if (done) begin
                    chk("done_busy", busy, 1'b0);
                    chk("done_clk_oe", ps2_clk_oe, 1'b0);
                    chk("done_data_oe", ps2_data_oe, 1'b0);
                    chk("done_ack_ok", ack_ok, exp_ack);
                    chk("done_error", error, exp_err);
                    done_cnt++;
                    done_cyc = cyc;
                    active = 1'b0;
                end else if (t >= 1) begin
                    chk("busy_during_xfer", busy, 1'b1);
                end
            end else begin
                chk("idle_busy", busy, 1'b0);
                chk("idle_done", done, 1'b0);
                chk("idle_clk_oe", ps2_clk_oe, 1'b0);
                chk("idle_data_oe", ps2_data_oe, 1'b0);
                if (done) done_cnt++;
            end
        end
    end

    task automatic start_and_wait_rts(input logic [7:0] b, input bit ack_expected);
        int n;
        exp_ack = ack_expected;
        exp_err = !ack_expected;
        @(posedge clk); #1;
        tx_data = b; tx_start = 1'b1; acc_cyc = cyc; active = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0; tx_data = ~b;
        n = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && n < int'(INH) + 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= int'(INH) + 20) chk("rts_wait_timeout", 32'd1, 32'd0);
    endtask

    // One device clock pulse; returns the data line level at the rising edge.
    task automatic dev_edge(input int k, input bit nack, output logic bit_seen);
        repeat (HALF) @(posedge clk);
        #1;
        if (k == 11) dev_data_low = !nack;
        dev_clk_low = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        bit_seen = ps2_data_in;
        dev_clk_low = 1'b0;
        if (k == 11) begin
            repeat (2) @(posedge clk);
            #1 dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (active && n < int'(TMO) + 100) begin
            @(posedge clk); #1; n++;
        end
        if (active) begin
            chk({name, "_done_timeout"}, 32'd1, 32'd0);
            active = 1'b0;
        end
    endtask

    task automatic do_xfer(input logic [7:0] b, input bit nack, input int stop_after,
                           output logic [9:0] got, output int unsigned pad4);
        logic s;
        got = '0;
        pad4 = 0;
        start_and_wait_rts(b, (!nack) && (stop_after >= 11));
        for (int k = 1; k <= stop_after; k++) begin
            if (k == 4) pad4 = cyc + HALF;
            dev_edge(k, nack, s);
            if (k <= 10) got[k-1] = s;
        end
        wait_done("xfer");
        repeat (10) @(posedge clk);
        #1;
    endtask

    logic [9:0]  got;
    int unsigned pad4;
    int          d0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack", ack_ok, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        clrn = 1'b1;
        repeat (3) @(posedge clk);

        chk("model_ED", model_frame(8'hED), 10'h3ED);
        chk("model_00", model_frame(8'h00), 10'h300);
        chk("model_01", model_frame(8'h01), 10'h201);

        d0 = done_cnt;
        do_xfer(8'hED, 1'b0, 11, got, pad4);
        chk("ED_frame", got, 10'h3ED);
        chk("ED_done_pulses", done_cnt - d0, 1);
        chk("ED_ack", ack_ok, 1'b1);
        chk("ED_err", error, 1'b0);

        d0 = done_cnt;
        do_xfer(8'h00, 1'b0, 11, got, pad4);
        chk("00_frame", got, model_frame(8'h00));
        chk("00_parity", got[8], 1'b1);
        chk("00_ack", ack_ok, 1'b1);
        chk("00_done_pulses", done_cnt - d0, 1);

        do_xfer(8'h01, 1'b0, 11, got, pad4);
        chk("01_frame", got, model_frame(8'h01));
        chk("01_parity", got[8], 1'b0);
        chk("01_ack", ack_ok, 1'b1);

        d0 = done_cnt;
        do_xfer(8'hA5, 1'b1, 11, got, pad4);
        chk("nack_frame", got, model_frame(8'hA5));
        chk("nack_err", error, 1'b1);
        chk("nack_ack", ack_ok, 1'b0);
        chk("nack_done_pulses", done_cnt - d0, 1);
        chk("nack_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

        d0 = done_cnt;
        do_xfer(8'h3C, 1'b0, 4, got, pad4);
        chk("tmo_latency", done_cyc - pad4, TMO + 4);
        chk("tmo_err", error, 1'b1);
        chk("tmo_ack", ack_ok, 1'b0);
        chk("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("tmo_done_pulses", done_cnt - d0, 1);

        fork
            do_xfer(8'h96, 1'b0, 11, got, pad4);
            begin
                repeat (6) @(posedge clk);
                #1 tx_data = 8'h55; tx_start = 1'b1;
                @(posedge clk);
                #1 tx_start = 1'b0;
            end
        join
        chk("busy_start_frame", got, model_frame(8'h96));
        chk("busy_start_ack", ack_ok, 1'b1);

        begin
            logic s;
            start_and_wait_rts(8'h42, 1'b1);
            for (int k = 1; k <= 3; k++) dev_edge(k, 1'b0, s);
            repeat (3) @(posedge clk);
            @(negedge clk);
            #2;
            active = 1'b0;
            clrn = 1'b0;
            #1;
            chk("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
            chk("rst_mid_data_oe", ps2_data_oe, 1'b0);
            chk("rst_mid_busy", busy, 1'b0);
            repeat (2) @(posedge clk);
            #1 clrn = 1'b1;
            repeat (3) @(posedge clk);
        end

        d0 = done_cnt;
        do_xfer(8'hFF, 1'b0, 11, got, pad4);
        chk("FF_frame", got, 10'h3FF);
        chk("FF_ack", ack_ok, 1'b1);
        chk("FF_done_pulses", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
